// File: rtl/store_commit_queue_if.sv
// store_commit_queue_if
//   Data-memory write port used by the store commit queue to drain
//   committed stores.
//   mem_we    - write request, held stable until accepted
//   mem_addr  - word address of the request
//   mem_wdata - write data of the request
//   mem_ready - memory accepts the pending request this cycle
//   Modports: master (the store queue side), slave (the memory side).
interface store_commit_queue_if #(
  parameter int ADDR_W = 10
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/store_commit_queue.sv
// store_commit_queue
//   In-order store queue on the commit side of the ROB. Entries are
//   allocated in program order, filled out of order by ROB tag, retired
//   in order (up to two per cycle) and drained one at a time to data
//   memory. Committed, filled, not-yet-freed stores forward to loads.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   alloc, alloc_tag      - allocate tail entry for an issued store
//   fill*/fill*2          - two execute ports writing addr/data by tag
//   ret, ret2             - retire one or two oldest stores
//   mem                   - data-memory write port (master side)
//   ld_addr               - load address for forwarding lookup
//   fwd_hit, fwd_data     - youngest committed store to ld_addr
//   sq_full, sq_empty, sq_count - occupancy from the registered count
module store_commit_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc,
  input  logic [4:0]                 alloc_tag,
  input  logic                       fill,
  input  logic [4:0]                 fill_tag,
  input  logic [ADDR_W-1:0]          fill_addr,
  input  logic [31:0]                fill_data,
  input  logic                       fill2,
  input  logic [4:0]                 fill_tag2,
  input  logic [ADDR_W-1:0]          fill_addr2,
  input  logic [31:0]                fill_data2,
  input  logic                       ret,
  input  logic                       ret2,
  store_commit_queue_if.master       mem,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       fwd_hit,
  output logic [31:0]                fwd_data,
  output logic                       sq_full,
  output logic                       sq_empty,
  output logic [$clog2(DEPTH):0]     sq_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [DEPTH-1:0]  valid_q, valid_d, filled_q, filled_d, committed_q, committed_d;
  logic [4:0]        tag_q  [DEPTH];
  logic [4:0]        tag_d  [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              free, alloc_ok, avail0, avail1;
  logic [PW-1:0]     cptr1, fwd_idx;
  logic [1:0]        n_req, n_ok;

  assign sq_full  = (count_q == CW'(DEPTH));
  assign sq_empty = (count_q == '0);
  assign sq_count = count_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign free = (state_q == ST_WRITE) && mem.mem_ready;
  // At full the slot being freed is the tail slot, so an alloc in the same
  // cycle can reuse it and the count holds.
  assign alloc_ok = alloc && (!sq_full || free);

  always_comb begin
    valid_d     = valid_q;
    filled_d    = filled_q;
    committed_d = committed_q;
    tag_d       = tag_q;
    addr_d      = addr_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Fill CAM; port 2 is applied last so it wins on a shared tag.
    for (int i = 0; i < DEPTH; i++) begin
      if (fill && valid_q[i] && tag_q[i] == fill_tag) begin
        filled_d[i] = 1'b1;
        addr_d[i]   = fill_addr;
        data_d[i]   = fill_data;
      end
      if (fill2 && valid_q[i] && tag_q[i] == fill_tag2) begin
        filled_d[i] = 1'b1;
        addr_d[i]   = fill_addr2;
        data_d[i]   = fill_data2;
      end
    end

    // Retire: entries from cptr to tail are exactly the uncommitted ones,
    // so checking the next two slots gives the clamp.
    cptr1  = cptr_q + PW'(1);
    avail0 = valid_q[cptr_q] && !committed_q[cptr_q];
    avail1 = avail0 && valid_q[cptr1] && !committed_q[cptr1];
    n_req  = {1'b0, ret} + {1'b0, ret2};
    n_ok   = 2'd0;
    if (n_req != 2'd0 && avail0) n_ok = 2'd1;
    if (n_req == 2'd2 && avail1) n_ok = 2'd2;
    if (n_ok != 2'd0) committed_d[cptr_q] = 1'b1;
    if (n_ok == 2'd2) committed_d[cptr1]  = 1'b1;
    cptr_d = cptr_q + PW'(n_ok);

    // Drain: request stays registered and stable until accepted.
    if (state_q == ST_IDLE) begin
      if (valid_q[head_q] && committed_q[head_q] && filled_q[head_q]) begin
        mem_addr_d  = addr_q[head_q];
        mem_wdata_d = data_q[head_q];
        mem_we_d    = 1'b1;
        state_d     = ST_WRITE;
      end
    end else if (mem.mem_ready) begin
      valid_d[head_q]     = 1'b0;
      filled_d[head_q]    = 1'b0;
      committed_d[head_q] = 1'b0;
      head_d   = head_q + PW'(1);
      mem_we_d = 1'b0;
      state_d  = ST_IDLE;
    end

    // Alloc last so it overrides fill and free on the same slot.
    if (alloc_ok) begin
      valid_d[tail_q]     = 1'b1;
      filled_d[tail_q]    = 1'b0;
      committed_d[tail_q] = 1'b0;
      tag_d[tail_q]       = alloc_tag;
      tail_d = tail_q + PW'(1);
    end

    count_d = count_q + CW'(alloc_ok) - CW'(free);
  end

  // Forwarding: committed entries are contiguous from head, so walking
  // oldest to youngest and letting later matches override picks the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if (valid_q[fwd_idx] && committed_q[fwd_idx] && filled_q[fwd_idx] &&
          addr_q[fwd_idx] == ld_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      filled_q    <= '0;
      committed_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q      <= '0;
      cptr_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      valid_q     <= valid_d;
      filled_q    <= filled_d;
      committed_q <= committed_d;
      tag_q       <= tag_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      head_q      <= head_d;
      cptr_q      <= cptr_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
endmodule
